vga_scanout: RTL and testbench

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_timing.sv | 44 ++++
 rtl/vga_scanout.sv | 95 +++++++++
 tb/tb_vga_scanout.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants, framebuffer geometry and the 3-bit colour type.
package vga_pkg;
   localparam int H_VIS_PX  = 640;
   localparam int H_FP      = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BP      = 48;
   localparam int H_TOTAL   = H_VIS_PX + H_FP + H_SYNC + H_BP;

   localparam int V_VIS_LN  = 480;
   localparam int V_FP      = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BP      = 33;
   localparam int V_TOTAL   = V_VIS_LN + V_FP + V_SYNC + V_BP;

   localparam int FB_W      = 160;
   localparam int FB_H      = 120;
   localparam int FB_ADDR_W = 15;
   localparam int CNT_W     = 10;

   typedef logic [2:0] colour_t;
endpackage

// File: rtl/vga_timing.sv
// Pixel-enable divider, raster counters and raw (unregistered) sync/visible decode.
module vga_timing
   import vga_pkg::*;
#(
   parameter int H_VIS = H_VIS_PX,
   parameter int V_VIS = V_VIS_LN
) (
   input  logic             clock,
   input  logic             reset,
   output logic             pix_en,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic             hs_raw,
   output logic             vs_raw,
   output logic             vis_raw
);
   localparam int H_END = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_END = V_VIS + V_FP + V_SYNC + V_BP;

   logic phase;

   always_ff @(posedge clock) begin
      if (reset) begin
         phase <= 1'b0;
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         phase <= ~phase;
         if (phase) begin
            if (h_cnt == CNT_W'(H_END - 1)) begin
               h_cnt <= '0;
               v_cnt <= (v_cnt == CNT_W'(V_END - 1)) ? '0 : v_cnt + CNT_W'(1);
            end else begin
               h_cnt <= h_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign pix_en  = phase;
   assign hs_raw  = !((h_cnt >= CNT_W'(H_VIS + H_FP)) && (h_cnt < CNT_W'(H_VIS + H_FP + H_SYNC)));
   assign vs_raw  = !((v_cnt >= CNT_W'(V_VIS + V_FP)) && (v_cnt < CNT_W'(V_VIS + V_FP + V_SYNC)));
   assign vis_raw = (h_cnt < CNT_W'(H_VIS)) && (v_cnt < CNT_W'(V_VIS));
endmodule

// File: rtl/vga_scanout.sv
// Framebuffer scan-out: address generation, one-pixel output pipeline, frame tick.
// Optional 8-bar test pattern (test_mode port) when VGA_SCANOUT_TESTPATTERN_EN is defined.
module vga_scanout
   import vga_pkg::*;
#(
   parameter int H_VIS      = H_VIS_PX,
   parameter int V_VIS      = V_VIS_LN,
   parameter int SCALE_LOG2 = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   output logic [FB_ADDR_W-1:0] rd_addr,
   input  colour_t              rd_data,
`ifdef VGA_SCANOUT_TESTPATTERN_EN
   input  logic                 test_mode,
`endif
   output logic                 vga_hs,
   output logic                 vga_vs,
   output logic                 vga_blank_n,
   output logic                 vga_sync_n,
   output logic [9:0]           vga_r,
   output logic [9:0]           vga_g,
   output logic [9:0]           vga_b,
   output logic                 frame_tick
);
   logic             pix_en, hs_raw, vs_raw, vis_raw;
   logic [CNT_W-1:0] h_cnt, v_cnt;

   vga_timing #(.H_VIS(H_VIS), .V_VIS(V_VIS)) u_timing (
      .clock   (clock),
      .reset   (reset),
      .pix_en  (pix_en),
      .h_cnt   (h_cnt),
      .v_cnt   (v_cnt),
      .hs_raw  (hs_raw),
      .vs_raw  (vs_raw),
      .vis_raw (vis_raw)
   );

   logic [FB_ADDR_W-1:0] fb_x, fb_y, addr_calc, addr_hold;

   // y*160 as y*128 + y*32
   assign fb_x      = FB_ADDR_W'(h_cnt >> SCALE_LOG2);
   assign fb_y      = FB_ADDR_W'(v_cnt >> SCALE_LOG2);
   assign addr_calc = (fb_y << 7) + (fb_y << 5) + fb_x;

   always_ff @(posedge clock) begin
      if (reset)
         addr_hold <= '0;
      else if (vis_raw)
         addr_hold <= addr_calc;
   end

   assign rd_addr = vis_raw ? addr_calc : addr_hold;

   colour_t pix_colour;
`ifdef VGA_SCANOUT_TESTPATTERN_EN
   colour_t bar;
   // bars are 80 px wide, so the index is h/80 rather than raw counter bits
   always_comb begin
      bar = '0;
      for (int i = 1; i < 8; i++)
         if (h_cnt >= CNT_W'(i * 80)) bar = bar + colour_t'(1);
   end
   assign pix_colour = test_mode ? bar : rd_data;
`else
   assign pix_colour = rd_data;
`endif

   logic    hs_q, vs_q, blank_n_q;
   colour_t rgb_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         blank_n_q <= 1'b0;
         rgb_q     <= '0;
      end else if (pix_en) begin
         hs_q      <= hs_raw;
         vs_q      <= vs_raw;
         blank_n_q <= vis_raw;
         rgb_q     <= vis_raw ? pix_colour : colour_t'(0);
      end
   end

   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign vga_blank_n = blank_n_q;
   assign vga_sync_n  = 1'b0;
   assign vga_r       = {10{rgb_q[2]}};
   assign vga_g       = {10{rgb_q[1]}};
   assign vga_b       = {10{rgb_q[0]}};
   assign frame_tick  = pix_en && (h_cnt == '0) && (v_cnt == CNT_W'(V_VIS));
endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: full-size instance for line timing and colour,
// reduced instance (32x4 visible) for frame-level timing within a short run.
`timescale 1ns/1ps
module tb_vga_scanout;
   logic clock = 1'b0;
   always #10 clock = ~clock;

   logic        reset_d = 1'b1, reset_s = 1'b1;
   logic [14:0] addr_d, addr_s;
   logic [2:0]  data_d = '0, data_s = '0;
   logic        hs_d, vs_d, bn_d, sn_d, ft_d;
   logic        hs_s, vs_s, bn_s, sn_s, ft_s;
   logic [9:0]  r_d, g_d, b_d, r_s, g_s, b_s;
   logic        white = 1'b0;
`ifdef VGA_SCANOUT_TESTPATTERN_EN
   logic        test_mode = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int edge_n   = 0;

   always @(posedge clock) begin
      data_d <= white ? 3'b111 : addr_d[2:0];
      data_s <= addr_s[2:0];
   end

   vga_scanout dut_d (
      .clock(clock), .reset(reset_d), .rd_addr(addr_d), .rd_data(data_d),
`ifdef VGA_SCANOUT_TESTPATTERN_EN
      .test_mode(test_mode),
`endif
      .vga_hs(hs_d), .vga_vs(vs_d), .vga_blank_n(bn_d), .vga_sync_n(sn_d),
      .vga_r(r_d), .vga_g(g_d), .vga_b(b_d), .frame_tick(ft_d)
   );

   vga_scanout #(.H_VIS(32), .V_VIS(4)) dut_s (
      .clock(clock), .reset(reset_s), .rd_addr(addr_s), .rd_data(data_s),
`ifdef VGA_SCANOUT_TESTPATTERN_EN
      .test_mode(test_mode),
`endif
      .vga_hs(hs_s), .vga_vs(vs_s), .vga_blank_n(bn_s), .vga_sync_n(sn_s),
      .vga_r(r_s), .vga_g(g_s), .vga_b(b_s), .frame_tick(ft_s)
   );

   function automatic logic [29:0] rgb_of(input logic [2:0] c);
      return {{10{c[2]}}, {10{c[1]}}, {10{c[0]}}};
   endfunction

   // Edge numbering: edge 1 is the first rising edge after reset deasserts.
   // Counters hold pixel n from edge 2n; outputs show pixel n from edge 2n+2.
   task automatic apply_reset_d();
      reset_d = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset_d = 1'b0;
      edge_n = 0;
   endtask

   task automatic apply_reset_s();
      reset_s = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset_s = 1'b0;
      edge_n = 0;
   endtask

   task automatic step_to(input int target);
      while (edge_n < target) begin
         @(posedge clock);
         #1 edge_n++;
      end
   endtask

   // kind 0: rd_addr, kind 1: visible colour, kind 2: blanked pixel
   int col_e[14] = '{7, 8, 10, 16, 18, 1280, 1282, 1400, 1600, 4812, 6080, 6400, 6402, 6418};
   int col_k[14] = '{0, 0, 1,  1,  1,  1,    2,    0,    0,    1,    0,    0,    1,    1};
   int col_v[14] = '{0, 1, 1,  1,  2,  7,    0,    159,  0,    1,    159,  160,  0,    2};

   int wht_e[4] = '{202, 1292, 1562, 1602};
   int wht_k[4] = '{1,   2,    2,    1};

   task automatic test_reset();
      reset_d = 1'b1;
      reset_s = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      n_checks += 9;
      if (hs_d !== 1'b1) begin n_fail++; $display("FAIL reset_hs: got %b expected 1", hs_d); end
      if (vs_d !== 1'b1) begin n_fail++; $display("FAIL reset_vs: got %b expected 1", vs_d); end
      if (bn_d !== 1'b0) begin n_fail++; $display("FAIL reset_blank_n: got %b expected 0", bn_d); end
      if (sn_d !== 1'b0) begin n_fail++; $display("FAIL reset_sync_n: got %b expected 0", sn_d); end
      if ({r_d, g_d, b_d} !== 30'd0) begin n_fail++; $display("FAIL reset_rgb: got %h expected 0", {r_d, g_d, b_d}); end
      if (ft_d !== 1'b0) begin n_fail++; $display("FAIL reset_frame_tick: got %b expected 0", ft_d); end
      if (addr_d !== 15'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d expected 0", addr_d); end
      if (ft_s !== 1'b0) begin n_fail++; $display("FAIL reset_small_frame_tick: got %b expected 0", ft_s); end
      if (hs_s !== 1'b1) begin n_fail++; $display("FAIL reset_small_hs: got %b expected 1", hs_s); end
   endtask

   task automatic test_colour();
      logic [29:0] got;
      white = 1'b0;
      apply_reset_d();
      for (int i = 0; i < 14; i++) begin
         step_to(col_e[i]);
         got = {r_d, g_d, b_d};
         if (col_k[i] == 0) begin
            n_checks++;
            if (addr_d !== 15'(col_v[i])) begin
               n_fail++;
               $display("FAIL addr[%0d] edge %0d: got %0d expected %0d", i, col_e[i], addr_d, col_v[i]);
            end
         end else if (col_k[i] == 1) begin
            n_checks += 2;
            if (got !== rgb_of(3'(col_v[i]))) begin
               n_fail++;
               $display("FAIL colour[%0d] edge %0d: got %h expected %h", i, col_e[i], got, rgb_of(3'(col_v[i])));
            end
            if (bn_d !== 1'b1) begin
               n_fail++;
               $display("FAIL colour_blank_n[%0d] edge %0d: got %b expected 1", i, col_e[i], bn_d);
            end
         end else begin
            n_checks += 2;
            if (got !== 30'd0) begin
               n_fail++;
               $display("FAIL blanked_rgb[%0d] edge %0d: got %h expected 0", i, col_e[i], got);
            end
            if (bn_d !== 1'b0) begin
               n_fail++;
               $display("FAIL blanked_blank_n[%0d] edge %0d: got %b expected 0", i, col_e[i], bn_d);
            end
         end
      end
   endtask

   task automatic test_white();
      logic [29:0] exp;
      white = 1'b1;
      apply_reset_d();
      for (int i = 0; i < 4; i++) begin
         step_to(wht_e[i]);
         exp = (wht_k[i] == 1) ? 30'h3FFF_FFFF : 30'd0;
         n_checks++;
         if ({r_d, g_d, b_d} !== exp) begin
            n_fail++;
            $display("FAIL white[%0d] edge %0d: got %h expected %h", i, wht_e[i], {r_d, g_d, b_d}, exp);
         end
      end
      white = 1'b0;
   endtask

   task automatic test_hsync();
      int fall1 = -1, rise1 = -1, fall2 = -1, vs_low = 0;
      logic prev = 1'b1;
      apply_reset_d();
      for (int e = 1; e <= 3400; e++) begin
         step_to(e);
         if (prev && !hs_d) begin
            if (fall1 < 0) fall1 = e;
            else if (fall2 < 0) fall2 = e;
         end
         if (!prev && hs_d && rise1 < 0) rise1 = e;
         if (!vs_d) vs_low++;
         prev = hs_d;
      end
      n_checks += 4;
      if (fall1 !== 1314) begin n_fail++; $display("FAIL hs_first_fall: got %0d expected 1314", fall1); end
      if (rise1 - fall1 !== 192) begin n_fail++; $display("FAIL hs_low_width: got %0d expected 192", rise1 - fall1); end
      if (fall2 - fall1 !== 1600) begin n_fail++; $display("FAIL hs_period: got %0d expected 1600", fall2 - fall1); end
      if (vs_low !== 0) begin n_fail++; $display("FAIL vs_idle_first_lines: got %0d low samples expected 0", vs_low); end
   endtask

   task automatic test_midline_reset();
      int fall1 = -1;
      logic prev = 1'b1;
      apply_reset_d();
      step_to(2200);
      reset_d = 1'b1;
      @(posedge clock);
      #1;
      n_checks++;
      if (bn_d !== 1'b0 || hs_d !== 1'b1) begin
         n_fail++;
         $display("FAIL midline_reset_state: got blank_n=%b hs=%b expected blank_n=0 hs=1", bn_d, hs_d);
      end
      reset_d = 1'b0;
      edge_n = 0;
      for (int e = 1; e <= 1400; e++) begin
         step_to(e);
         if (prev && !hs_d && fall1 < 0) fall1 = e;
         prev = hs_d;
      end
      n_checks++;
      if (fall1 !== 1314) begin n_fail++; $display("FAIL midline_reset_hs_fall: got %0d expected 1314", fall1); end
   endtask

   task automatic test_vsync();
      int fall1 = -1, rise1 = -1, fall2 = -1, ft1 = -1, ft2 = -1, ft_cnt = 0, hs_fall = -1;
      logic prev = 1'b1, prev_hs = 1'b1;
      apply_reset_s();
      for (int e = 1; e <= 24500; e++) begin
         step_to(e);
         if (prev && !vs_s) begin
            if (fall1 < 0) fall1 = e;
            else if (fall2 < 0) fall2 = e;
         end
         if (!prev && vs_s && rise1 < 0) rise1 = e;
         if (prev_hs && !hs_s && hs_fall < 0) hs_fall = e;
         if (ft_s) begin
            ft_cnt++;
            if (ft1 < 0) ft1 = e;
            else if (ft2 < 0) ft2 = e;
         end
         prev = vs_s;
         prev_hs = hs_s;
      end
      n_checks += 7;
      if (fall1 !== 5378) begin n_fail++; $display("FAIL vs_first_fall: got %0d expected 5378", fall1); end
      if (rise1 - fall1 !== 768) begin n_fail++; $display("FAIL vs_low_width: got %0d expected 768", rise1 - fall1); end
      if (fall2 - fall1 !== 18816) begin n_fail++; $display("FAIL vs_period: got %0d expected 18816", fall2 - fall1); end
      if (ft1 !== 1537) begin n_fail++; $display("FAIL frame_tick_first: got %0d expected 1537", ft1); end
      if (ft2 - ft1 !== 18816) begin n_fail++; $display("FAIL frame_tick_period: got %0d expected 18816", ft2 - ft1); end
      if (ft_cnt !== 2) begin n_fail++; $display("FAIL frame_tick_count: got %0d expected 2", ft_cnt); end
      if (hs_fall !== 98) begin n_fail++; $display("FAIL small_hs_first_fall: got %0d expected 98", hs_fall); end
   endtask

   task automatic test_frame_reset();
      int hs_fall = -1, ft1 = -1, vs_low = 0;
      logic prev = 1'b1;
      apply_reset_s();
      step_to(808);
      reset_s = 1'b1;
      @(posedge clock);
      #1 reset_s = 1'b0;
      edge_n = 0;
      for (int e = 1; e <= 1600; e++) begin
         step_to(e);
         if (prev && !hs_s && hs_fall < 0) hs_fall = e;
         if (ft_s && ft1 < 0) ft1 = e;
         if (!vs_s) vs_low++;
         prev = hs_s;
      end
      n_checks += 3;
      if (hs_fall !== 98) begin n_fail++; $display("FAIL frame_reset_hs_fall: got %0d expected 98", hs_fall); end
      if (ft1 !== 1537) begin n_fail++; $display("FAIL frame_reset_tick: got %0d expected 1537", ft1); end
      if (vs_low !== 0) begin n_fail++; $display("FAIL frame_reset_vs: got %0d low samples expected 0", vs_low); end
   endtask

`ifdef VGA_SCANOUT_TESTPATTERN_EN
   int tp_e[6] = '{2, 160, 162, 320, 1122, 1280};
   int tp_v[6] = '{0, 0,   1,   1,   7,    7};

   task automatic test_pattern();
      test_mode = 1'b1;
      white = 1'b1;
      apply_reset_d();
      for (int i = 0; i < 6; i++) begin
         step_to(tp_e[i]);
         n_checks++;
         if ({r_d, g_d, b_d} !== rgb_of(3'(tp_v[i]))) begin
            n_fail++;
            $display("FAIL pattern[%0d] edge %0d: got %h expected %h", i, tp_e[i], {r_d, g_d, b_d}, rgb_of(3'(tp_v[i])));
         end
      end
      test_mode = 1'b0;
      white = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_colour();
      test_white();
      test_hsync();
      test_midline_reset();
      test_vsync();
      test_frame_reset();
`ifdef VGA_SCANOUT_TESTPATTERN_EN
      test_pattern();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
